ped_signal_controller: RTL and testbench
========================================

// Module: ped_signal_controller
// PURPOSE
//  Pedestrian crossing stage downstream of traffic_controller. Consumes the vehicle red/yellow/green
//  lights plus a raw crossing button, and drives WALK / flashing DON'T-WALK / solid DON'T-WALK.
//  A latched request is served only at the start of a vehicle red phase.
//  Aborts to solid DON'T-WALK the moment vehicle red ends or the light inputs become invalid.
// PARAMETERS
//  walk_time    15  cycles of solid WALK per crossing (>=1)
//  flash_time   8   cycles of flashing DON'T-WALK after WALK (>=1)
//  flash_period 2   cycles per flash half-period (>=1)
//  CNT_W        8   width of timer and ped_count; must hold walk_time+flash_time
//  Constraint: walk_time+flash_time <= traffic_controller red_time.
// PORTS
//  clk           in  1      system clock, rising edge
//  reset         in  1      asynchronous, active-low; all state cleared while low
//  red_light     in  1      vehicle red from traffic_controller
//  yellow_light  in  1      vehicle yellow
//  green_light   in  1      vehicle green
//  ped_button    in  1      raw pedestrian button, asynchronous to clk
//  walk          out 1      WALK lamp
//  dont_walk     out 1      DON'T-WALK lamp (solid or flashing)
//  req_pending   out 1      request latched, not yet served
//  fault         out 1      light inputs not one-hot
//  ped_count     out CNT_W  remaining crossing cycles
// BEHAVIOUR
//  Reset (reset=0): state IDLE, walk=0, dont_walk=1, req_pending=0, fault=0, ped_count=0, timer=0,
//   sync flops=0, red_d=0. Applies immediately, including mid-WALK or mid-FLASH.
//  Button: 2-flop synchroniser, then rising-edge detect (s2 & ~s3).
//   A press is first visible on req_pending after the 3rd clk edge. Holding the button high = one request.
//  Request set: on a button edge in IDLE or FAULT. Edges seen in WALK/FLASH are dropped.
//  Request clear: only on normal FLASH completion.
//  red_rise = red_light & ~red_d, where red_d is red_light registered.
//  valid = {red,yellow,green} is one-hot.
//  States and outputs:
//   IDLE   walk=0, dont_walk=1.
//          Go to WALK when valid & red_rise & req_pending; load timer = walk_time-1.
//          A request latched while red is already on waits for the next red_rise.
//   WALK   walk=1, dont_walk=0. Timer decrements each cycle.
//          At timer==0, go to FLASH; load timer = flash_time-1; phase=1; phase counter cleared.
//   FLASH  walk=0, dont_walk=phase. phase starts at 1 and toggles every flash_period cycles.
//          At timer==0, go to IDLE and clear req_pending.
//   FAULT  walk=0, dont_walk=1, fault=1. Go to IDLE on the first valid cycle; req_pending is kept.
//  Priority, evaluated every cycle:
//   1. !valid -> FAULT, from any state.
//   2. WALK/FLASH with red_light==0 -> IDLE (abort). req_pending is kept, so the crossing is
//      served on the next red_rise.
//   3. Normal transitions above.
//  Outputs are registered. A state change is visible on the edge after the causing input is sampled.
//  Timers never wrap; the timer holds 0 outside WALK/FLASH.
// CONFIGURATION
//  PED_COUNTDOWN_EN defined:
//   ped_count = timer+1+flash_time in WALK, timer+1 in FLASH, 0 in IDLE/FAULT.
//   Updates each cycle; reaches 1 on the last FLASH cycle, then 0.
//  Not defined: ped_count tied to 0 and no countdown logic is built. All other behaviour is identical.
// TESTING (walk_time=4, flash_time=4, flash_period=1, clk period 10ns)
//  1. Hold reset=0 -> walk=0, dont_walk=1, req_pending=0, fault=0, ped_count=0.
//     Pulse reset low mid-WALK -> same values immediately.
//  2. Green on; 1-cycle ped_button pulse -> req_pending=1 after 3rd edge. Then red_rise ->
//     walk=1 for 4 cycles; dont_walk 1,0,1,0 over 4 FLASH cycles; then dont_walk=1, req_pending=0.
//  3. No button through a full red phase -> walk stays 0, dont_walk stays 1.
//     Button held high 50 cycles -> exactly one crossing.
//  4. Request served; red->yellow on WALK cycle 2 -> next edge walk=0, dont_walk=1, req_pending=1.
//     Next red_rise -> full 4+4 crossing.
//  5. red & green both high 1 cycle during WALK -> fault=1, walk=0, dont_walk=1.
//     Next valid cycle -> fault=0, IDLE.
//  6. PED_COUNTDOWN_EN: crossing -> ped_count 8,7,6,5,4,3,2,1 then 0.
//     Without the macro -> ped_count=0 throughout.

Source files
------------

// File: rtl/ped_signal_controller.sv
// Pedestrian crossing stage: serves a latched button request at the start of vehicle red.
// Optional `PED_COUNTDOWN_EN builds a remaining-crossing-cycles counter on ped_count.
module ped_signal_controller #(
  parameter int unsigned walk_time    = 15,
  parameter int unsigned flash_time   = 8,
  parameter int unsigned flash_period = 2,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red_light,
  input  logic             yellow_light,
  input  logic             green_light,
  input  logic             ped_button,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending,
  output logic             fault,
  output logic [CNT_W-1:0] ped_count
);

  localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(walk_time - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD  = CNT_W'(flash_time - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(flash_period - 1);

  typedef enum logic [1:0] {IDLE, WALK, FLASH, FAULT} state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] phase_cnt;
  logic             phase;
  logic             btn_s1, btn_s2, btn_s3;
  logic             red_d;
  logic             btn_edge;
  logic             red_rise;
  logic             valid;

  assign btn_edge = btn_s2 & ~btn_s3;
  assign red_rise = red_light & ~red_d;
  assign valid    = $onehot({red_light, yellow_light, green_light});

  // Button synchroniser plus edge-detect stage, and red delay for rise detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
      red_d  <= 1'b0;
    end else begin
      btn_s1 <= ped_button;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      red_d  <= red_light;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      fault       <= 1'b0;
      timer       <= '0;
      phase_cnt   <= '0;
      phase       <= 1'b1;
    end else begin
      if (btn_edge && (state == IDLE || state == FAULT)) req_pending <= 1'b1;
      if (!valid) begin
        state     <= FAULT;
        walk      <= 1'b0;
        dont_walk <= 1'b1;
        fault     <= 1'b1;
        timer     <= '0;
        phase_cnt <= '0;
      end else begin
        fault <= 1'b0;
        case (state)
          IDLE: begin
            if (red_rise && req_pending) begin
              state     <= WALK;
              walk      <= 1'b1;
              dont_walk <= 1'b0;
              timer     <= WALK_LOAD;
            end
          end
          WALK: begin
            if (!red_light) begin
              state     <= IDLE;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              timer     <= '0;
            end else if (timer == '0) begin
              state     <= FLASH;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              timer     <= FLASH_LOAD;
              phase     <= 1'b1;
              phase_cnt <= '0;
            end else begin
              timer <= timer - CNT_W'(1);
            end
          end
          FLASH: begin
            if (!red_light) begin
              state     <= IDLE;
              dont_walk <= 1'b1;
              timer     <= '0;
            end else if (timer == '0) begin
              state       <= IDLE;
              dont_walk   <= 1'b1;
              req_pending <= 1'b0;
            end else begin
              timer <= timer - CNT_W'(1);
              if (phase_cnt == PERIOD_LAST) begin
                phase     <= ~phase;
                dont_walk <= ~phase;
                phase_cnt <= '0;
              end else begin
                phase_cnt <= phase_cnt + CNT_W'(1);
              end
            end
          end
          FAULT: begin
            state     <= IDLE;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef PED_COUNTDOWN_EN
  localparam logic [CNT_W-1:0] TOTAL_LEN = CNT_W'(walk_time + flash_time);

  // Remaining crossing cycles simply count down by one from crossing start to the last FLASH cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_count <= '0;
    end else if (!valid) begin
      ped_count <= '0;
    end else begin
      case (state)
        IDLE:        ped_count <= (red_rise && req_pending) ? TOTAL_LEN : '0;
        WALK, FLASH: ped_count <= (!red_light || (state == FLASH && timer == '0)) ? '0
                                                                                  : ped_count - CNT_W'(1);
        default:     ped_count <= '0;
      endcase
    end
  end
`else
  assign ped_count = '0;
`endif

endmodule

// File: tb/tb_ped_signal_controller.sv
// Directed table-driven bench for ped_signal_controller (walk=4, flash=4, flash_period=1).
module tb_ped_signal_controller;

  localparam int unsigned CNT_W = 8;
  localparam logic [2:0] LR   = 3'b100;
  localparam logic [2:0] LY   = 3'b010;
  localparam logic [2:0] LG   = 3'b001;
  localparam logic [2:0] LRG  = 3'b101;
  localparam logic [2:0] LOFF = 3'b000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             red_light = 1'b0;
  logic             yellow_light = 1'b0;
  logic             green_light = 1'b1;
  logic             ped_button = 1'b0;
  logic             walk, dont_walk, req_pending, fault;
  logic [CNT_W-1:0] ped_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ped_signal_controller #(
    .walk_time(4), .flash_time(4), .flash_period(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .red_light(red_light), .yellow_light(yellow_light), .green_light(green_light),
    .ped_button(ped_button),
    .walk(walk), .dont_walk(dont_walk), .req_pending(req_pending), .fault(fault),
    .ped_count(ped_count)
  );

  typedef struct {
    logic [2:0] lights;
    logic       btn;
    logic       w, dw, rq, f;
    logic [7:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] l, input logic b, input logic w, input logic dw,
                     input logic rq, input logic f, input logic [7:0] pc);
    vec_t v;
    v.lights = l; v.btn = b; v.w = w; v.dw = dw; v.rq = rq; v.f = f; v.pc = pc;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] exp_pc(input logic [7:0] pc);
`ifdef PED_COUNTDOWN_EN
    return pc;
`else
    return (pc == 8'd0) ? 8'd0 : 8'd0;
`endif
  endfunction

  task automatic check(input string name, input logic w, input logic dw, input logic rq,
                       input logic f, input logic [7:0] pc);
    logic [11:0] act, want;
    act  = {walk, dont_walk, req_pending, fault, ped_count};
    want = {w, dw, rq, f, exp_pc(pc)};
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got walk=%b dont_walk=%b req=%b fault=%b cnt=%0d, want walk=%b dont_walk=%b req=%b fault=%b cnt=%0d",
               name, walk, dont_walk, req_pending, fault, ped_count, w, dw, rq, f, exp_pc(pc));
    end
  endtask

  task automatic check_int(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic cycle(input logic [2:0] l, input logic b);
    @(negedge clk);
    {red_light, yellow_light, green_light} = l;
    ped_button = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int walk_cycles;
    int walk_rises;
    logic prev_walk;
    logic [2:0] l;

    // Normal crossing after a green-phase press
    add(LG,1, 0,1,0,0,0); add(LG,0, 0,1,0,0,0); add(LG,0, 0,1,1,0,0); add(LG,0, 0,1,1,0,0);
    add(LY,0, 0,1,1,0,0);
    add(LR,0, 1,0,1,0,8); add(LR,0, 1,0,1,0,7); add(LR,0, 1,0,1,0,6); add(LR,0, 1,0,1,0,5);
    add(LR,0, 0,1,1,0,4); add(LR,0, 0,0,1,0,3); add(LR,0, 0,1,1,0,2); add(LR,0, 0,0,1,0,1);
    add(LR,0, 0,1,0,0,0); add(LR,0, 0,1,0,0,0);
    // Full red phase with no request
    add(LG,0, 0,1,0,0,0); add(LG,0, 0,1,0,0,0); add(LY,0, 0,1,0,0,0);
    for (int i = 0; i < 8; i++) add(LR,0, 0,1,0,0,0);
    // Press while red already on waits for the next red rise, then abort on green
    add(LR,1, 0,1,0,0,0); add(LR,0, 0,1,0,0,0); add(LR,0, 0,1,1,0,0); add(LR,0, 0,1,1,0,0);
    add(LY,0, 0,1,1,0,0); add(LR,0, 1,0,1,0,8); add(LG,0, 0,1,1,0,0);
    // Abort on yellow during WALK cycle 2, then a full crossing; press inside WALK is dropped
    add(LG,1, 0,1,1,0,0); add(LG,0, 0,1,1,0,0); add(LY,0, 0,1,1,0,0);
    add(LR,0, 1,0,1,0,8); add(LR,0, 1,0,1,0,7); add(LY,0, 0,1,1,0,0); add(LY,0, 0,1,1,0,0);
    add(LR,1, 1,0,1,0,8); add(LR,0, 1,0,1,0,7); add(LR,0, 1,0,1,0,6); add(LR,0, 1,0,1,0,5);
    add(LR,0, 0,1,1,0,4); add(LR,0, 0,0,1,0,3); add(LR,0, 0,1,1,0,2); add(LR,0, 0,0,1,0,1);
    add(LR,0, 0,1,0,0,0);
    // Invalid lights during WALK and in IDLE
    add(LG,1, 0,1,0,0,0); add(LG,0, 0,1,0,0,0); add(LG,0, 0,1,1,0,0); add(LY,0, 0,1,1,0,0);
    add(LR,0, 1,0,1,0,8); add(LRG,0, 0,1,1,1,0); add(LR,0, 0,1,1,0,0); add(LY,0, 0,1,1,0,0);
    add(LR,0, 1,0,1,0,8); add(LG,0, 0,1,1,0,0);
    add(LOFF,0, 0,1,1,1,0); add(LG,0, 0,1,1,0,0);

    // Reset held low
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 0,1,0,0,0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].lights, vecs[i].btn);
      check($sformatf("vec%0d", i), vecs[i].w, vecs[i].dw, vecs[i].rq, vecs[i].f, vecs[i].pc);
    end

    // Asynchronous reset mid-WALK (request still pending from the last table rows)
    cycle(LY, 0);
    cycle(LR, 0);
    check("pre_reset_walk", 1,0,1,0,8);
    cycle(LR, 0);
    #2;
    reset = 1'b0;
    #1;
    check("reset_mid_walk", 0,1,0,0,0);
    @(negedge clk);
    reset = 1'b1;

    // Button held high for 50 cycles yields exactly one crossing
    walk_cycles = 0;
    walk_rises  = 0;
    prev_walk   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < 20)      l = LG;
      else if (i < 22) l = LY;
      else if (i < 37) l = LR;
      else if (i < 53) l = LG;
      else if (i < 54) l = LY;
      else             l = LR;
      cycle(l, (i < 50) ? 1'b1 : 1'b0);
      if (walk) walk_cycles++;
      if (walk && !prev_walk) walk_rises++;
      prev_walk = walk;
    end
    check_int("held_walk_cycles", walk_cycles, 4);
    check_int("held_crossings", walk_rises, 1);
    check("held_end", 0,1,0,0,0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
